// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, port indices, widths.
package dmem_arb_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam logic PortP0 = 1'b0;
  localparam logic PortP1 = 1'b1;

  localparam int unsigned DataW = 64;
  localparam int unsigned CntW  = 16;

  // One-hot vector selecting the given port index.
  function automatic logic [1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: prio names the port that wins when both are valid.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       grant_idx
);

  // Single requester always wins; on a tie the priority port wins.
  always_comb begin
    grant     = 2'b00;
    grant_idx = prio;
    if (valid[0] && valid[1]) begin
      grant     = port_onehot(prio);
      grant_idx = prio;
    end else if (valid[0]) begin
      grant     = 2'b01;
      grant_idx = PortP0;
    end else if (valid[1]) begin
      grant     = 2'b10;
      grant_idx = PortP1;
    end
  end

endmodule

// File: rtl/dmem_arb.sv
// Two-port data-memory arbiter: one outstanding access, round-robin grant, per-access timeout.
module dmem_arb
  import dmem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DataW-1:0] p0_req_addr,
  input  logic [DataW-1:0] p0_req_wdata,
  input  logic             p0_req_wen,
  input  logic             p0_req_valid,
  output logic             p0_req_ready,
  output logic [DataW-1:0] p0_resp_rdata,
  output logic             p0_resp_valid,
  output logic             p0_resp_err,
  input  logic [DataW-1:0] p1_req_addr,
  input  logic [DataW-1:0] p1_req_wdata,
  input  logic             p1_req_wen,
  input  logic             p1_req_valid,
  output logic             p1_req_ready,
  output logic [DataW-1:0] p1_resp_rdata,
  output logic             p1_resp_valid,
  output logic             p1_resp_err,
  output logic [DataW-1:0] dm_req_addr,
  output logic [DataW-1:0] dm_req_wdata,
  output logic             dm_req_wen,
  output logic             dm_req_valid,
  input  logic [DataW-1:0] dm_resp_rdata,
  input  logic             dm_resp_valid
);

  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             prio_q, prio_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [DataW-1:0] addr_q, addr_d;
  logic [DataW-1:0] wdata_q, wdata_d;
  logic             wen_q, wen_d;
  logic             valid_q, valid_d;

  logic [1:0] grant;
  logic       grant_idx;
  logic       timeout_hit;

  rr_arb2 u_rr_arb2 (
    .valid     ({p1_req_valid, p0_req_valid}),
    .prio      (prio_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign timeout_hit = (state_q == StBusy) && (cnt_q == TimeoutLast);

  assign dm_req_addr  = addr_q;
  assign dm_req_wdata = wdata_q;
  assign dm_req_wen   = wen_q;
  assign dm_req_valid = valid_q;

  // State register; reset abandons any outstanding access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= PortP0;
      prio_q  <= PortP0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wen_q   <= wen_d;
      valid_q <= valid_d;
    end
  end

  // Next-state: capture on grant, count while waiting, finish on response or timeout.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    prio_d  = prio_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wen_d   = wen_q;
    valid_d = valid_q;
    unique case (state_q)
      StIdle: begin
        if (|grant) begin
          state_d = StBusy;
          owner_d = grant_idx;
          prio_d  = ~grant_idx;
          cnt_d   = '0;
          addr_d  = grant_idx ? p1_req_addr  : p0_req_addr;
          wdata_d = grant_idx ? p1_req_wdata : p0_req_wdata;
          wen_d   = grant_idx ? p1_req_wen   : p0_req_wen;
          valid_d = 1'b1;
        end
      end
      StBusy: begin
        if (dm_resp_valid || timeout_hit) begin
          state_d = StIdle;
          cnt_d   = '0;
          valid_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        valid_d = 1'b0;
      end
    endcase
  end

  // Outputs: ready only while idle, completion routed to the owner; a response beats a timeout.
  always_comb begin
    p0_req_ready  = 1'b0;
    p1_req_ready  = 1'b0;
    p0_resp_valid = 1'b0;
    p1_resp_valid = 1'b0;
    p0_resp_err   = 1'b0;
    p1_resp_err   = 1'b0;
    p0_resp_rdata = '0;
    p1_resp_rdata = '0;
    if (!rst) begin
      unique case (state_q)
        StIdle: begin
          p0_req_ready = grant[0];
          p1_req_ready = grant[1];
        end
        StBusy: begin
          if (dm_resp_valid) begin
            if (owner_q == PortP1) begin
              p1_resp_valid = 1'b1;
              p1_resp_rdata = dm_resp_rdata;
            end else begin
              p0_resp_valid = 1'b1;
              p0_resp_rdata = dm_resp_rdata;
            end
          end else if (timeout_hit) begin
            if (owner_q == PortP1) begin
              p1_resp_valid = 1'b1;
              p1_resp_err   = 1'b1;
            end else begin
              p0_resp_valid = 1'b1;
              p0_resp_err   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arb.sv
// Directed table-driven bench for dmem_arb (TIMEOUT = 4).
module tb_dmem_arb;

  localparam int unsigned Tmo = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] p0_req_addr, p0_req_wdata, p1_req_addr, p1_req_wdata;
  logic        p0_req_wen, p0_req_valid, p1_req_wen, p1_req_valid;
  logic        p0_req_ready, p1_req_ready;
  logic [63:0] p0_resp_rdata, p1_resp_rdata;
  logic        p0_resp_valid, p0_resp_err, p1_resp_valid, p1_resp_err;
  logic [63:0] dm_req_addr, dm_req_wdata, dm_resp_rdata;
  logic        dm_req_wen, dm_req_valid, dm_resp_valid;

  int errors = 0;
  int checks = 0;

  dmem_arb #(.TIMEOUT(Tmo)) dut (
    .clk           (clk),
    .rst           (rst),
    .p0_req_addr   (p0_req_addr),
    .p0_req_wdata  (p0_req_wdata),
    .p0_req_wen    (p0_req_wen),
    .p0_req_valid  (p0_req_valid),
    .p0_req_ready  (p0_req_ready),
    .p0_resp_rdata (p0_resp_rdata),
    .p0_resp_valid (p0_resp_valid),
    .p0_resp_err   (p0_resp_err),
    .p1_req_addr   (p1_req_addr),
    .p1_req_wdata  (p1_req_wdata),
    .p1_req_wen    (p1_req_wen),
    .p1_req_valid  (p1_req_valid),
    .p1_req_ready  (p1_req_ready),
    .p1_resp_rdata (p1_resp_rdata),
    .p1_resp_valid (p1_resp_valid),
    .p1_resp_err   (p1_resp_err),
    .dm_req_addr   (dm_req_addr),
    .dm_req_wdata  (dm_req_wdata),
    .dm_req_wen    (dm_req_wen),
    .dm_req_valid  (dm_req_valid),
    .dm_resp_rdata (dm_resp_rdata),
    .dm_resp_valid (dm_resp_valid)
  );

  always #5 clk = ~clk;

  // delay = BUSY cycle in which memory answers (0 = never); busy = expected dm_req_valid cycles
  typedef struct {
    logic        p0v;
    logic        p1v;
    logic        wen;
    int          delay;
    logic [63:0] addr;
    logic [63:0] rdata;
    logic [1:0]  grant;
    int          busy;
    logic        err;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic p0v, input logic p1v, input logic wen, input int delay,
                              input logic [63:0] addr, input logic [63:0] rdata,
                              input logic [1:0] grant, input int busy, input logic err);
    vec_t v;
    v.p0v = p0v; v.p1v = p1v; v.wen = wen; v.delay = delay; v.addr = addr;
    v.rdata = rdata; v.grant = grant; v.busy = busy; v.err = err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t  v;
    logic  done;
    int    hi;
    logic [63:0] exp_data;

    // Both valid from reset alternate p0, p1, p0, p1.
    vecs[0] = mk(1, 1, 0, 1, 64'h100, 64'hA0, 2'b01, 1, 0);
    vecs[1] = mk(1, 1, 0, 1, 64'h200, 64'hA1, 2'b10, 1, 0);
    vecs[2] = mk(1, 1, 0, 2, 64'h300, 64'hA2, 2'b01, 2, 0);
    vecs[3] = mk(1, 1, 0, 1, 64'h400, 64'hA3, 2'b10, 1, 0);
    // p0 load at 0x1000, answer in 3rd BUSY cycle.
    vecs[4] = mk(1, 0, 0, 3, 64'h1000, 64'hDEADBEEF, 2'b01, 3, 0);
    // p1 store never answered: timeout in 4th BUSY cycle.
    vecs[5] = mk(0, 1, 1, 0, 64'h2000, 64'h55, 2'b10, 4, 1);
    // Response coinciding with the timeout cycle wins.
    vecs[6] = mk(1, 0, 0, 4, 64'h3000, 64'h1234_5678, 2'b01, 4, 0);
    // Lone p1 granted back-to-back, even when p0 holds priority.
    vecs[7] = mk(0, 1, 0, 2, 64'h4000, 64'hB7, 2'b10, 2, 0);
    vecs[8] = mk(0, 1, 0, 1, 64'h5000, 64'hB8, 2'b10, 1, 0);
    vecs[9] = mk(1, 0, 0, 1, 64'h6000, 64'hB9, 2'b01, 1, 0);

    rst = 1'b1;
    p0_req_addr = '0; p0_req_wdata = '0; p0_req_wen = 1'b0; p0_req_valid = 1'b1;
    p1_req_addr = '0; p1_req_wdata = '0; p1_req_wen = 1'b0; p1_req_valid = 1'b1;
    dm_resp_rdata = '0; dm_resp_valid = 1'b0;

    // Reset state, with both requesters pending.
    @(negedge clk);
    @(negedge clk);
    chk("rst_dm_valid", 64'(dm_req_valid), 64'd0);
    chk("rst_dm_wen", 64'(dm_req_wen), 64'd0);
    chk("rst_dm_addr", dm_req_addr, 64'd0);
    chk("rst_dm_wdata", dm_req_wdata, 64'd0);
    chk("rst_ready", 64'({p1_req_ready, p0_req_ready}), 64'd0);
    chk("rst_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      if (i > 0) @(negedge clk);
      chk($sformatf("v%0d_idle_dm_valid", i), 64'(dm_req_valid), 64'd0);
      p0_req_valid = v.p0v;  p1_req_valid = v.p1v;
      p0_req_addr  = v.addr; p1_req_addr  = v.addr + 64'h100;
      p0_req_wen   = 1'b0;   p1_req_wen   = v.wen;
      p0_req_wdata = 64'hC0 + 64'(i); p1_req_wdata = 64'hC1 + 64'(i);
      #1;
      chk($sformatf("v%0d_ready", i), 64'({p1_req_ready, p0_req_ready}), 64'(v.grant));
      done = 1'b0;
      hi = 0;
      for (int k = 1; k <= int'(Tmo) + 2 && !done; k++) begin
        @(negedge clk);
        if (k == 1) begin
          chk($sformatf("v%0d_dm_addr", i), dm_req_addr,
              v.grant[1] ? v.addr + 64'h100 : v.addr);
          chk($sformatf("v%0d_dm_wen", i), 64'(dm_req_wen), 64'(v.grant[1] & v.wen));
        end
        if (v.delay == k) begin
          dm_resp_valid = 1'b1;
          dm_resp_rdata = v.rdata;
        end
        #1;
        chk($sformatf("v%0d_busy_ready", i), 64'({p1_req_ready, p0_req_ready}), 64'd0);
        if (dm_req_valid) hi++;
        if (p0_resp_valid || p1_resp_valid) begin
          done = 1'b1;
          exp_data = v.err ? 64'd0 : v.rdata;
          chk($sformatf("v%0d_resp_valid", i), 64'({p1_resp_valid, p0_resp_valid}),
              64'(v.grant));
          chk($sformatf("v%0d_resp_err", i), 64'({p1_resp_err, p0_resp_err}),
              v.err ? 64'(v.grant) : 64'd0);
          chk($sformatf("v%0d_p0_rdata", i), p0_resp_rdata, v.grant[0] ? exp_data : 64'd0);
          chk($sformatf("v%0d_p1_rdata", i), p1_resp_rdata, v.grant[1] ? exp_data : 64'd0);
        end
      end
      chk($sformatf("v%0d_done", i), 64'(done), 64'd1);
      chk($sformatf("v%0d_dm_valid_cycles", i), 64'(hi), 64'(v.busy));
      @(posedge clk);
      #1;
      dm_resp_valid = 1'b0;
      p0_req_valid = 1'b0;
      p1_req_valid = 1'b0;
    end

    // Memory response while idle is ignored.
    @(negedge clk);
    chk("idle_resp_dm_valid_before", 64'(dm_req_valid), 64'd0);
    dm_resp_valid = 1'b1;
    dm_resp_rdata = 64'hFFFF;
    #1;
    chk("idle_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
    @(negedge clk);
    chk("idle_resp_no_busy", 64'(dm_req_valid), 64'd0);
    dm_resp_valid = 1'b0;
    // Priority is p1 (last grant p0); a lone p0 is still granted, making priority p1 again.
    p0_req_valid = 1'b1;
    p0_req_addr = 64'h7000;
    #1;
    chk("pre_rst_ready", 64'({p1_req_ready, p0_req_ready}), 64'b01);
    @(negedge clk);
    chk("pre_rst_busy", 64'(dm_req_valid), 64'd1);
    // Reset mid-BUSY with both requesting: access dropped silently, p0 first afterwards.
    p1_req_valid = 1'b1;
    p1_req_addr = 64'h8000;
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_dm_valid", 64'(dm_req_valid), 64'd0);
    chk("midrst_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
    chk("midrst_ready", 64'({p1_req_ready, p0_req_ready}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_ready", 64'({p1_req_ready, p0_req_ready}), 64'b01);
    chk("postrst_resp_valid", 64'({p1_resp_valid, p0_resp_valid}), 64'd0);
    @(negedge clk);
    chk("postrst_dm_valid", 64'(dm_req_valid), 64'd1);
    chk("postrst_dm_addr", dm_req_addr, 64'h7000);
    p0_req_valid = 1'b0;
    p1_req_valid = 1'b0;
    dm_resp_valid = 1'b1;
    dm_resp_rdata = 64'h77;
    #1;
    chk("postrst_p0_resp", 64'({p1_resp_valid, p0_resp_valid}), 64'b01);
    chk("postrst_p0_rdata", p0_resp_rdata, 64'h77);
    @(negedge clk);
    dm_resp_valid = 1'b0;
    chk("final_idle", 64'(dm_req_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: the number of BUSY cycles without a response before an access is aborted; legal range 1..65535.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset; asynchronous, active-high.
REQ-004 SHALL have ports p0_req_addr / p1_req_addr, input, 64 bits: requester byte address (p0 = load-store pipeline, p1 = secondary master).
REQ-005 SHALL have ports p0_req_wdata / p1_req_wdata, input, 64 bits: store data.
REQ-006 SHALL have ports p0_req_wen / p1_req_wen, input, 1 bit: 1 = store, 0 = load.
REQ-007 SHALL have ports p0_req_valid / p1_req_valid, input, 1 bit: request present.
REQ-008 SHALL have ports p0_req_ready / p1_req_ready, output, 1 bit: request accepted this cycle.
REQ-009 SHALL have ports p0_resp_rdata / p1_resp_rdata, output, 64 bits: load data.
REQ-010 SHALL have ports p0_resp_valid / p1_resp_valid, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have ports p0_resp_err / p1_resp_err, output, 1 bit: completion was a timeout; qualified by resp_valid.
REQ-012 SHALL have ports dm_req_addr, dm_req_wdata, output, 64 bits each, registered: memory request address and data.
REQ-013 SHALL have ports dm_req_wen, dm_req_valid, output, 1 bit each, registered: memory request type and valid.
REQ-014 SHALL have ports dm_resp_rdata, input, 64 bits, and dm_resp_valid, input, 1 bit: memory response.

Function
REQ-015 SHALL implement a two-state FSM: IDLE and BUSY; at most one access outstanding.
REQ-016 In IDLE, SHALL grant exactly one valid requester, with round-robin priority: the port not granted last wins a tie; after reset p0 has priority.
REQ-017 SHALL assert pX_req_ready combinationally in IDLE only for the granted port; it SHALL be 0 in BUSY.
REQ-018 On a grant at edge N, SHALL register addr/wdata/wen, set dm_req_valid=1, record the owner, clear the timeout counter and enter BUSY, so that dm_req_valid is high in cycle N+1.
REQ-019 In BUSY, SHALL hold dm_req_valid and the request fields stable until completion.
REQ-020 In BUSY, when dm_resp_valid=1, SHALL drive owner resp_valid=1, resp_err=0 and resp_rdata=dm_resp_rdata in the same cycle (combinational), then at the next edge drop dm_req_valid and return to IDLE.
REQ-021 The non-owner's resp_valid SHALL remain 0, and resp_rdata SHALL be 0 for the non-owner.
REQ-022 The counter (16 bits) SHALL increment each BUSY cycle without a response; at count == TIMEOUT-1 it SHALL pulse owner resp_valid=1, resp_err=1, resp_rdata=0, clear dm_req_valid and return to IDLE.
REQ-023 If a response and a timeout coincide, the response SHALL win (err=0).
REQ-024 dm_resp_valid in IDLE SHALL be ignored.
REQ-025 The minimum occupancy is 2 cycles per access (grant edge, response cycle); a new grant is possible only in the IDLE cycle after completion.
REQ-026 The grant pointer SHALL update only on an actual grant.
REQ-027 A single requester continuously valid SHALL be granted every IDLE cycle.

Reset
REQ-028 While rst=1, SHALL force state IDLE, dm_req_valid=0, dm_req_wen=0, dm_req_addr=0, dm_req_wdata=0, counter=0, owner=p0, priority=p0.
REQ-029 All resp_valid and req_ready outputs SHALL be 0 during reset.
REQ-030 Reset asserted during BUSY SHALL drop the outstanding access with no response pulse.

Structure
REQ-031 SHALL place the FSM state encoding (IDLE=0, BUSY=1) and the port-index constants in the shared defines header.
REQ-032 SHALL factor the grant logic (2 valids, last-grant pointer -> one-hot grant) into sub-module rr_arb2.

Verification
REQ-033 SHALL cover: p0 load at addr 0x1000 only, memory replies 0xDEADBEEF after 3 cycles -> p0_resp_valid one pulse carrying 0xDEADBEEF, p1 silent, dm_req_valid high for exactly 3 cycles.
REQ-034 SHALL cover: p0 and p1 both valid from reset -> grant order p0, p1, p0, p1 over four accesses.
REQ-035 SHALL cover: TIMEOUT=4, p1 store with no response -> p1_resp_valid with err=1 in the 4th BUSY cycle, dm_req_valid low afterwards, FSM back in IDLE.
REQ-036 SHALL cover: TIMEOUT=4, response arriving in the 4th BUSY cycle -> err=0 and the data is delivered.
REQ-037 SHALL cover: rst pulsed mid-BUSY -> dm_req_valid=0 immediately, no resp pulse, and the next grant goes to p0.
REQ-038 SHALL cover: dm_resp_valid asserted while IDLE -> no resp_valid on either port and no state change.
